// File: rtl/ir_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and instruction memory (slave).
interface ir_fetch_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_data;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/ir_fetch.sv
// Instruction fetch / IR stage: one-deep pending fetch, decoded IR fields, fetch counter.
// Optional hung-memory watchdog enabled by defining IR_TIMEOUT_EN.
module ir_fetch #(
    parameter int AW = 16,
    parameter int DW = 32
`ifdef IR_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 16
`endif
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          ir_load,
    input  logic [AW-1:0] pc_in,
    ir_fetch_if.master    imem,
    output logic [DW-1:0] ir_out,
    output logic [3:0]    opcode,
    output logic [3:0]    mm,
    output logic [3:0]    rd,
    output logic [3:0]    rs,
    output logic [3:0]    rt,
    output logic [15:0]   imm,
    output logic          ir_valid,
    output logic          busy,
    output logic [15:0]   fetch_cnt,
    output logic          fetch_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] ir_q, ir_d;
    logic          valid_q, valid_d;
    logic          pend_q, pend_d;
    logic          busy_q, busy_d;
    logic [15:0]   cnt_q, cnt_d;

`ifdef IR_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);

    logic            err_q, err_d;
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    // Next-state logic for the fetch FSM, IR capture, pend flag and counters
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        valid_d = 1'b0;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
`ifdef IR_TIMEOUT_EN
        err_d   = err_q;
        wd_d    = wd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ir_load) begin
                    addr_d  = pc_in;
                    req_d   = 1'b1;
                    pend_d  = 1'b0;
                    state_d = ST_WAIT;
`ifdef IR_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end else begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (imem.imem_ack) begin
                    ir_d    = imem.imem_data;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
`ifdef IR_TIMEOUT_EN
                    wd_d    = '0;
`endif
                    // A queued or same-cycle strobe chains straight into the next fetch
                    if (pend_q || ir_load) begin
                        addr_d  = pc_in;
                        req_d   = 1'b1;
                        pend_d  = 1'b0;
                        state_d = ST_WAIT;
                    end else begin
                        req_d   = 1'b0;
                        pend_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
`ifdef IR_TIMEOUT_EN
                else if (wd_q == WD_LIMIT) begin
                    ir_d    = '0;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    pend_d  = 1'b0;
                    err_d   = 1'b1;
                    wd_d    = '0;
                    state_d = ST_IDLE;
                end
`endif
                else begin
                    if (ir_load) begin
                        pend_d = 1'b1;
                    end else begin
                        pend_d = pend_q;
                    end
`ifdef IR_TIMEOUT_EN
                    wd_d = wd_q + WD_W'(1);
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                pend_d  = 1'b0;
            end
        endcase
        busy_d = (state_d == ST_WAIT) | pend_d;
    end

    // State registers with synchronous reset; reset leaves a NOOP in the IR
    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            ir_q    <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= 16'd0;
`ifdef IR_TIMEOUT_EN
            err_q   <= 1'b0;
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
`ifdef IR_TIMEOUT_EN
            err_q   <= err_d;
            wd_q    <= wd_d;
`endif
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign ir_out         = ir_q;
    assign ir_valid       = valid_q;
    assign busy           = busy_q;
    assign fetch_cnt      = cnt_q;
`ifdef IR_TIMEOUT_EN
    assign fetch_err      = err_q;
`else
    assign fetch_err      = 1'b0;
`endif

    // Decoded fields are plain slices of the IR
    assign opcode = ir_q[31:28];
    assign mm     = ir_q[27:24];
    assign rd     = ir_q[23:20];
    assign rs     = ir_q[19:16];
    assign rt     = ir_q[15:12];
    assign imm    = ir_q[15:0];

endmodule

// File: tb/tb_ir_fetch.sv
// Scoreboard bench for ir_fetch: randomized fetch traffic against a transaction-level
// model (outstanding-request count), plus directed reset, chaining, timeout and wrap cases.
module tb_ir_fetch;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 16;
`ifdef IR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_f;
    logic          ir_load;
    logic [AW-1:0] pc_in;
    logic [DW-1:0] ir_out;
    logic [3:0]    opcode, mm, rd, rs, rt;
    logic [15:0]   imm;
    logic          ir_valid, busy, fetch_err;
    logic [15:0]   fetch_cnt;

    ir_fetch_if #(.AW(AW), .DW(DW)) imem ();

    ir_fetch #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_f(rst_f), .ir_load(ir_load), .pc_in(pc_in), .imem(imem),
        .ir_out(ir_out), .opcode(opcode), .mm(mm), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
        .ir_valid(ir_valid), .busy(busy), .fetch_cnt(fetch_cnt), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [15:0] c;
        logic        e;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          outst = 0;
    int          nack  = 0;
    logic [15:0] addr_m = 16'd0;
    logic [15:0] cnt_m  = 16'd0;
    logic        err_m  = 1'b0;
    logic [31:0] ir_m   = 32'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Abstract model: number of requested-but-unanswered fetches (0..2) and current address
    task automatic model_step(input logic ld, input logic [15:0] pc, input logic ack,
                              input logic [31:0] dat, input logic rst);
        if (rst) begin
            outst = 0; nack = 0; cnt_m = 16'd0; err_m = 1'b0; ir_m = 32'd0;
        end else if (outst == 0) begin
            if (ld) begin
                outst = 1; addr_m = pc; nack = 0;
            end
        end else if (ack) begin
            cnt_m = cnt_m + 16'd1;
            ir_m  = dat;
            sb.push_back('{d: dat, c: cnt_m, e: err_m});
            if (outst == 2 || ld) outst = 1;
            else outst = 0;
            if (outst > 0) begin
                addr_m = pc; nack = 0;
            end
        end else begin
            nack++;
            if (TO_EN && nack == TO) begin
                outst = 0; ir_m = 32'd0; err_m = 1'b1;
                sb.push_back('{d: 32'd0, c: cnt_m, e: 1'b1});
            end else if (ld) begin
                outst = 2;
            end
        end
    endtask

    task automatic check_cycle();
        chk("imem_req", 64'(imem.imem_req), 64'(outst > 0));
        if (outst > 0) chk("imem_addr", 64'(imem.imem_addr), 64'(addr_m));
        chk("busy", 64'(busy), 64'(outst > 0));
        chk("ir_out", 64'(ir_out), 64'(ir_m));
        chk("fetch_cnt", 64'(fetch_cnt), 64'(cnt_m));
        chk("fetch_err", 64'(fetch_err), 64'(err_m));
    endtask

    task automatic cycle(input logic ld, input logic [15:0] pc, input logic ack,
                         input logic [31:0] dat, input logic rst);
        rst_f = rst; ir_load = ld; pc_in = pc;
        imem.imem_ack = ack; imem.imem_data = dat;
        @(posedge clk);
        model_step(ld, pc, ack, dat, rst);
        @(negedge clk);
        check_cycle();
    endtask

    // Monitor: every ir_valid pulse must match the oldest expected capture
    always @(negedge clk) begin
        if (ir_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_ir_valid: got pulse with ir_out %0h expected none", ir_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_ir_out", 64'(ir_out), 64'(e.d));
                chk("mon_opcode", 64'(opcode), 64'(e.d >> 28) & 64'hF);
                chk("mon_mm", 64'(mm), 64'(e.d >> 24) & 64'hF);
                chk("mon_rd", 64'(rd), 64'(e.d >> 20) & 64'hF);
                chk("mon_rs", 64'(rs), 64'(e.d >> 16) & 64'hF);
                chk("mon_rt", 64'(rt), 64'(e.d >> 12) & 64'hF);
                chk("mon_imm", 64'(imm), 64'(e.d) & 64'hFFFF);
                chk("mon_cnt", 64'(fetch_cnt), 64'(e.c));
                chk("mon_err", 64'(fetch_err), 64'(e.e));
            end
        end
    end

    initial begin
        int pct;
        rst_f = 1'b1; ir_load = 1'b0; pc_in = 16'd0;
        imem.imem_ack = 1'b0; imem.imem_data = 32'd0;

        cycle(1'b0, 16'd0, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 16'd0, 1'b0, 32'd0, 1'b1);
        chk("reset_opcode", 64'(opcode), 64'd0);

        // Reset while a fetch is waiting; later acks must be ignored
        cycle(1'b0, 16'd0, 1'b0, 32'd0, 1'b0);
        cycle(1'b1, 16'h1234, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 32'hF000_0001, 1'b1);
        cycle(1'b0, 16'h0, 1'b1, 32'hF000_0002, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 32'hF000_0003, 1'b0);
        chk("midreset_opcode", 64'(opcode), 64'd0);

        // Basic fetch, ack three edges after the strobe
        cycle(1'b1, 16'h0010, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 32'h8123_4005, 1'b0);
        chk("basic_opcode", 64'(opcode), 64'd8);
        chk("basic_imm", 64'(imm), 64'h4005);
        cycle(1'b0, 16'h0000, 1'b0, 32'd0, 1'b0);
        chk("basic_valid_one_cycle", 64'(ir_valid), 64'd0);

        // Back-to-back via pend
        cycle(1'b1, 16'h0020, 1'b0, 32'd0, 1'b0);
        cycle(1'b1, 16'h0011, 1'b0, 32'd0, 1'b0);
        cycle(1'b1, 16'h0011, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 16'h0011, 1'b1, 32'h1111_2222, 1'b0);
        chk("b2b_addr", 64'(imem.imem_addr), 64'h0011);
        cycle(1'b0, 16'h0000, 1'b1, 32'h3333_4444, 1'b0);

        // Same-cycle strobe+ack, then a stray ack in IDLE
        cycle(1'b1, 16'h0030, 1'b0, 32'd0, 1'b0);
        cycle(1'b1, 16'h0031, 1'b1, 32'h5555_6666, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 32'h7777_8888, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 32'h9999_AAAA, 1'b0);

        // Memory that never answers (watchdog case when enabled), then a normal fetch
        cycle(1'b1, 16'h0040, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 16'h0000, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 32'hBBBB_CCCC, 1'b0);
        cycle(1'b1, 16'h0041, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 32'hDDDD_EEEE, 1'b0);

        // Randomized traffic with varying memory responsiveness
        pct = 30;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                case ($urandom_range(2, 0))
                    0: pct = 3;
                    1: pct = 30;
                    default: pct = 75;
                endcase
            end
            cycle(1'($urandom_range(99, 0) < 35), 16'($urandom),
                  1'($urandom_range(99, 0) < pct), $urandom,
                  1'($urandom_range(999, 0) == 0));
        end

        // Continuous chained fetches: one capture per cycle, forces fetch_cnt to wrap
        for (int i = 0; i < 65540; i++) cycle(1'b1, 16'($urandom), 1'b1, $urandom, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b1, 32'd0, 1'b0);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
